ofifo_psum: RTL and testbench
=============================

// Module: ofifo_psum
// PURPOSE
//  Output-side collector directly south of the MAC tile array.
//  - One circular FIFO per column captures that column's bottom-row out_s psum.
//  - Columns finish at skewed times; a row is presented to the readout/SFP stage
//    only once every column holds at least one entry (column-aligned rows).
// PARAMETERS
//  col      8   number of array columns / lanes
//  psum_bw  16  psum width per lane, signed two's complement
//  depth    8   entries per column FIFO; power of two, >=2
// PORTS
//  clk      in   1              rising-edge clock
//  reset    in   1              async, active-low; 0 = reset asserted
//  wr       in   col            per-column write strobe; bit i captures in lane i
//  in       in   col*psum_bw    lane i = in[psum_bw*(i+1)-1 : psum_bw*i]
//  rd       in   1              pop one aligned row from all columns
//  out      out  col*psum_bw    head row, same lane packing as in
//  o_valid  out  1              every column non-empty; out is a valid row
//  o_full   out  1              at least one column is full
//  o_ovf    out  1              sticky: a write hit a full column and was dropped
// BEHAVIOUR
//  - Reset (async, while reset==0):
//    - all write pointers, the read pointer and per-column counts = 0; o_ovf = 0
//    - o_valid = 0, o_full = 0, out = 0; storage contents are don't-care
//    - a reset mid-stream discards every stored entry
//  - Pointers:
//    - per-column write pointer plus per-column count, log2(depth)+1 bits
//    - one shared read pointer (all columns are popped together)
//    - pointers wrap modulo depth
//  - Write:
//    - wr[i] at edge N stores lane i at wptr[i]; the entry is counted from N+1
//    - write to a full column: entry dropped, pointer and count unchanged, o_ovf <= 1
//  - Read:
//    - out is first-word-fall-through: combinational from storage[rptr]
//    - rd && o_valid: rptr advances at the edge and every count decrements
//    - rd while !o_valid: ignored, no state change
//  - Simultaneous write and read:
//    - wr[i] && rd && o_valid on column i: count unchanged, both pointers advance
//    - applies when column i is full: the write is accepted, since the read frees a slot
//  - Flags:
//    - o_valid = AND over columns of (count != 0)
//    - o_full = OR over columns of (count == depth)
//    - both combinational from registered counts; no combinational path from wr/rd
//  - Latency: write at edge N to o_valid high in cycle N+1 (if it was the last missing column)
//  - Arithmetic: lanes are stored and passed unmodified; no width change
//  - o_ovf: cleared only by reset
// CONFIGURATION
//  - OFIFO_RELU_EN defined:
//    - each lane of out with a negative value (MSB=1) is forced to 0
//    - combinational on the read side; storage holds raw values
//  - OFIFO_RELU_EN undefined: out is the raw stored psum
// STRUCTURE
//  - Shared package psum_pkg:
//    - constants COL, PSUM_BW, OFIFO_DEPTH and PTR_W = $clog2(OFIFO_DEPTH)
//    - typedef psum_t (signed [PSUM_BW-1:0])
//  - Sub-module ofifo_col:
//    - a single-column FIFO with its own wptr, count and full/empty flags
//    - instantiated col times via generate
//    - top level owns the shared rptr, flag reduction, o_ovf and the ReLU option
// TESTING
//  1. Reset: reset=0 mid-stream with 3 rows stored -> o_valid=0, o_full=0, o_ovf=0, out=0;
//     after release, rd=1 with no writes -> no pointer movement.
//  2. Skewed fill: wr bit i asserted at cycle i (col=8), lane value 16'h0100+i
//     -> o_valid stays 0 until the cycle after the col-7 write; out lane i = 16'h0100+i.
//  3. Depth/wrap: 20 aligned rows written with rd interleaved, max 8 outstanding
//     -> rows read back in order, o_full=1 at exactly 8 outstanding, o_ovf=0.
//  4. Overflow: 9 writes to col 0 only -> o_full=1 after 8, 9th dropped, o_ovf=1 and stays 1.
//  5. Full + simultaneous: all columns full, wr=8'hFF with rd=1 -> count stays 8,
//     head advances, new row readable 8 pops later, o_ovf=0.
//  6. ReLU: with OFIFO_RELU_EN, lane value 16'hFFF0 -> out lane 0, and 16'h0010 -> 16'h0010;
//     without OFIFO_RELU_EN, 16'hFFF0 passes unchanged.

Source files
------------

// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared constants and psum type for the output FIFO collector
package psum_pkg;
    localparam int COL         = 8;
    localparam int PSUM_BW     = 16;
    localparam int OFIFO_DEPTH = 8;
    localparam int PTR_W       = $clog2(OFIFO_DEPTH);

    typedef logic signed [PSUM_BW-1:0] psum_t;
endpackage

// File: rtl/ofifo_psum_if.sv
// rtl/ofifo_psum_if.sv - write/read bus between the MAC array, ofifo_psum and readout
interface ofifo_psum_if;
    import psum_pkg::*;

    logic [COL-1:0]         wr;
    logic [COL*PSUM_BW-1:0] in;
    logic                   rd;
    logic [COL*PSUM_BW-1:0] out;
    logic                   o_valid;
    logic                   o_full;
    logic                   o_ovf;

    modport master (output wr, in, rd, input out, o_valid, o_full, o_ovf);
    modport slave  (input wr, in, rd, output out, o_valid, o_full, o_ovf);
endinterface

// File: rtl/ofifo_col.sv
// rtl/ofifo_col.sv - single-column circular FIFO; read pointer is supplied by the parent
module ofifo_col
    import psum_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  psum_t            wr_data,
    input  logic             pop,
    input  logic [PTR_W-1:0] rptr,
    output psum_t            rd_data,
    output logic             full,
    output logic             empty,
    output logic             drop
);
    psum_t            mem [OFIFO_DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W:0]   count;
    logic             push;

    assign full    = (count == (PTR_W+1)'(OFIFO_DEPTH));
    assign empty   = (count == '0);
    // A pop in the same cycle frees a slot, so a write to a full column is still taken.
    assign push    = wr_en && (!full || pop);
    assign drop    = wr_en && full && !pop;
    assign rd_data = mem[rptr];

    // Write pointer and occupancy count; count is unchanged when push and pop coincide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_data;
    end
endmodule

// File: rtl/ofifo_psum.sv
// rtl/ofifo_psum.sv - column-aligned output FIFO below the MAC array; optional OFIFO_RELU_EN
module ofifo_psum
    import psum_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    ofifo_psum_if.slave bus
);
    logic [PTR_W-1:0] rptr;
    logic [COL-1:0]   col_full;
    logic [COL-1:0]   col_empty;
    logic [COL-1:0]   col_drop;
    psum_t            lane_raw [COL];
    logic             ovf_q;
    logic             pop;
    psum_t            lane;

    // Flags come only from registered counts, so no wr/rd combinational path.
    assign bus.o_valid = ~|col_empty;
    assign bus.o_full  = |col_full;
    assign bus.o_ovf   = ovf_q;
    assign pop         = bus.rd && bus.o_valid;

    for (genvar i = 0; i < COL; i++) begin : g_col
        ofifo_col u_col (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (bus.wr[i]),
            .wr_data (bus.in[PSUM_BW*i +: PSUM_BW]),
            .pop     (pop),
            .rptr    (rptr),
            .rd_data (lane_raw[i]),
            .full    (col_full[i]),
            .empty   (col_empty[i]),
            .drop    (col_drop[i])
        );
    end

    // Shared read pointer and sticky overflow flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rptr  <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (pop)
                rptr <= rptr + 1'b1;
            if (|col_drop)
                ovf_q <= 1'b1;
        end
    end

    // Head row readout; lanes read as zero until a complete row is present.
    always_comb begin
        bus.out = '0;
        lane    = '0;
        for (int i = 0; i < COL; i++) begin
            lane = bus.o_valid ? lane_raw[i] : '0;
`ifdef OFIFO_RELU_EN
            if (lane[PSUM_BW-1])
                lane = '0;
`endif
            bus.out[PSUM_BW*i +: PSUM_BW] = lane;
        end
    end
endmodule

// File: tb/tb_ofifo_psum.sv
// tb/tb_ofifo_psum.sv - self-checking bench for ofifo_psum
module tb_ofifo_psum;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    ofifo_psum_if bus ();
    ofifo_psum dut (.clk(clk), .reset(reset), .bus(bus));

    typedef logic [15:0] lq_t[$];
    lq_t  mq [8];
    logic movf = 1'b0;

    typedef struct {
        int          lane;
        logic [15:0] val;
        logic        exp_valid;
        logic        exp_full;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef OFIFO_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic m_valid();
        for (int i = 0; i < 8; i++)
            if (mq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < 8; i++)
            if (mq[i].size() == 8) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [127:0] m_out();
        logic [127:0] o = '0;
        if (m_valid())
            for (int i = 0; i < 8; i++) o[16*i +: 16] = relu(mq[i][0]);
        return o;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) mq[i].delete();
        movf = 1'b0;
    endtask

    task automatic m_update(input logic [7:0] w, input logic [127:0] d, input logic r);
        logic pop;
        pop = r && m_valid();
        if (pop)
            for (int i = 0; i < 8; i++) void'(mq[i].pop_front());
        for (int i = 0; i < 8; i++)
            if (w[i]) begin
                if (mq[i].size() < 8) mq[i].push_back(d[16*i +: 16]);
                else movf = 1'b1;
            end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".valid"}, 128'(bus.o_valid), 128'(m_valid()));
        chk({tag, ".full"},  128'(bus.o_full),  128'(m_full()));
        chk({tag, ".ovf"},   128'(bus.o_ovf),   128'(movf));
        chk({tag, ".out"},   bus.out,           m_out());
    endtask

    task automatic step(input string tag, input logic [7:0] w, input logic [127:0] d, input logic r);
        bus.wr = w;
        bus.in = d;
        bus.rd = r;
        @(posedge clk);
        m_update(w, d, r);
        #1;
        bus.wr = '0;
        bus.rd = 1'b0;
        cmp_all(tag);
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        m_clear();
        #1;
        chk("rst.valid", 128'(bus.o_valid), 128'(0));
        chk("rst.full",  128'(bus.o_full),  128'(0));
        chk("rst.ovf",   128'(bus.o_ovf),   128'(0));
        chk("rst.out",   bus.out,           128'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] row(input logic [15:0] base);
        logic [127:0] d;
        for (int i = 0; i < 8; i++) d[16*i +: 16] = base + 16'(i);
        return d;
    endfunction

    initial begin
        logic [127:0] d;
        logic [127:0] newrow;
        int wrote;
        int outstanding;
        bus.wr = '0;
        bus.in = '0;
        bus.rd = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        cmp_all("por");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: reset mid-stream discards stored rows
        for (int r = 0; r < 3; r++) step("t1.fill", 8'hFF, row(16'h1000 + 16'(r * 16)), 1'b0);
        do_reset();
        step("t1.rdidle", 8'h00, '0, 1'b1);
        step("t1.wr", 8'hFF, row(16'h2000), 1'b0);
        chk("t1.head", bus.out, row(16'h2000));

        // Test 2: skewed fill, table of hand-derived expectations
        do_reset();
        for (int i = 0; i < 8; i++)
            tbl[i] = '{lane: i, val: 16'h0100 + 16'(i), exp_valid: (i == 7), exp_full: 1'b0};
        for (int i = 0; i < 8; i++) begin
            d = '0;
            d[16*tbl[i].lane +: 16] = tbl[i].val;
            step("t2.step", 8'(1 << tbl[i].lane), d, 1'b0);
            chk("t2.valid", 128'(bus.o_valid), 128'(tbl[i].exp_valid));
            chk("t2.full",  128'(bus.o_full),  128'(tbl[i].exp_full));
        end
        chk("t2.out", bus.out, row(16'h0100));

        // Test 3: 20 rows with interleaved reads, at most 8 outstanding
        do_reset();
        wrote = 0;
        outstanding = 0;
        while (wrote < 20 || outstanding > 0) begin
            logic w;
            logic r;
            w = (wrote < 20) && (outstanding < 8) && ($urandom_range(3) != 0);
            r = (outstanding > 0) && ((wrote == 20) || ($urandom_range(3) == 0));
            step("t3", w ? 8'hFF : 8'h00, row(16'h3000 + 16'(wrote * 8)), r);
            if (outstanding == 8 && !r && !w)
                chk("t3.full8", 128'(bus.o_full), 128'(1));
            if (w) wrote++;
            if (r) outstanding--;
            if (w) outstanding++;
        end
        chk("t3.ovf", 128'(bus.o_ovf), 128'(0));

        // Test 4: overflow on column 0
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step("t4", 8'h01, 128'(16'h4000 + 16'(i)), 1'b0);
            if (i == 7) chk("t4.full8", 128'(bus.o_full), 128'(1));
        end
        chk("t4.ovf", 128'(bus.o_ovf), 128'(1));
        step("t4.idle", 8'h00, '0, 1'b1);
        step("t4.idle", 8'h00, '0, 1'b0);
        chk("t4.sticky", 128'(bus.o_ovf), 128'(1));

        // Test 5: full columns, simultaneous write and read
        do_reset();
        for (int r = 0; r < 8; r++) step("t5.fill", 8'hFF, row(16'h5000 + 16'(r * 16)), 1'b0);
        newrow = row(16'h5A00);
        step("t5.both", 8'hFF, newrow, 1'b1);
        chk("t5.full", 128'(bus.o_full), 128'(1));
        chk("t5.head", bus.out, row(16'h5010));
        for (int r = 0; r < 7; r++) step("t5.pop", 8'h00, '0, 1'b1);
        chk("t5.newhead", bus.out, newrow);
        chk("t5.ovf", 128'(bus.o_ovf), 128'(0));

        // Test 6: negative and positive lanes through the read side
        do_reset();
        d = '0;
        for (int i = 0; i < 8; i++) d[16*i +: 16] = (i % 2 == 0) ? 16'hFFF0 : 16'h0010;
        step("t6", 8'hFF, d, 1'b0);
`ifdef OFIFO_RELU_EN
        chk("t6.neg", 128'(bus.out[15:0]), 128'(16'h0000));
`else
        chk("t6.neg", 128'(bus.out[15:0]), 128'(16'hFFF0));
`endif
        chk("t6.pos", 128'(bus.out[31:16]), 128'(16'h0010));

        // Random stress against the queue model
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 8; i++) d[16*i +: 16] = 16'($urandom);
            step("rnd", 8'($urandom), d, ($urandom_range(2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
